lap_stopwatch: RTL and testbench
================================

LAP_STOPWATCH -- requirements
Module: lap_stopwatch

Interface
REQ-001 Parameter DIGITS, default 4: number of decimal digits; legal range 2..8.
REQ-002 Parameter TICK_DIV, default 500000: clock cycles per count tick; legal range 2..2^24.
REQ-003 Parameter MS_MOD, default 6: modulus of the most-significant digit; legal range 2..10.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  system clock, all logic on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start_stop  input  1  asynchronous pushbutton level; each rising edge toggles run/stop.
REQ-008 lap  input  1  asynchronous pushbutton level; rising edge toggles display hold (see Configuration).
REQ-009 seg  output  7*DIGITS  active-low segments; digit k occupies seg[7k+6:7k], bit 6 = a ... bit 0 = g; digit 0 least significant.
REQ-010 running  output  1  high while in RUN state.
REQ-011 held  output  1  high while the display is frozen.
REQ-012 overflow  output  1  sticky; set when the count wraps from full scale to zero.

Function
REQ-013 start_stop and lap SHALL each pass a 2-flop synchronizer then a 1-flop edge detector; an edge is "seen" on the 3rd rising clock after the input is first sampled high.
REQ-014 FSM states: STOP, RUN; the cycle an edge is seen, STOP->RUN or RUN->STOP; running is registered and changes on the next clock edge.
REQ-015 Prescaler counts 0..TICK_DIV-1 only in RUN; at TICK_DIV-1 it emits a 1-cycle tick and returns to 0; in STOP it holds its value (not cleared).
REQ-016 On tick, digit 0 increments mod 10; digit k (k<DIGITS-1) increments when all lower digits are 9; digit DIGITS-1 is mod MS_MOD.
REQ-017 Full scale = MS_MOD*10^(DIGITS-1)-1; a tick at full scale SHALL wrap all digits to 0 and set overflow; counting continues.
REQ-018 Tick and start_stop edge in the same cycle: the tick is applied (count advances), then state changes.
REQ-019 Display value = live count, or the lap snapshot while held=1.
REQ-020 Segment decode per digit: 0..9 to standard 7-seg patterns, registered; seg reflects a count change one clock after it.
REQ-021 Patterns (a..g, 1 = lit, output inverted): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.

Reset
REQ-022 reset SHALL clear: state=STOP, prescaler=0, all digits=0, snapshot=0, held=0, overflow=0, synchronizer and edge flops=0.
REQ-023 After reset, seg SHALL show all digits "0" (7'b0000001 per digit) from the following clock.
REQ-024 reset mid-run SHALL take priority over tick and edges in that cycle; a button held high through reset release SHALL NOT produce an edge.

Configuration
REQ-025 Macro LAP_HOLD_EN defined: a lap edge seen in RUN with held=0 copies the live count to the snapshot and sets held; a lap edge with held=1 clears held; a lap edge in STOP with held=0 is ignored; counting is unaffected by held.
REQ-026 LAP_HOLD_EN undefined: lap is ignored, held is tied 0, snapshot register absent, display always live.

Verification (DIGITS=4, TICK_DIV=4, MS_MOD=6)
REQ-027 Reset, no buttons, 100 clocks -> running=0, seg all "0", overflow=0.
REQ-028 Pulse start_stop -> running=1 one clock after the edge is seen; digit 0 reads 1 after 4 further clocks, 9 after 36, 10 (digits 1,0) after 40.
REQ-029 Run to 5999, next tick -> display 0000, overflow=1 and stays 1 until reset.
REQ-030 Second start_stop pulse at count 0012 -> running=0, count frozen for 50 clocks; third pulse resumes with prescaler continuing from held value.
REQ-031 LAP_HOLD_EN: lap edge at count 0025 -> display frozen at 0025 while internal count reaches 0030; second lap edge -> display 0030.
REQ-032 Assert reset at count 0347 while running, start_stop held high through release -> all outputs reset values, running stays 0.

Source files
------------

// File: rtl/lap_stopwatch_if.sv
// Button inputs and display/status outputs of the lap stopwatch.
// DIGITS must match the stopwatch instance it connects to.
interface lap_stopwatch_if #(
  parameter int DIGITS = 4
);
  logic                  start_stop;
  logic                  lap;
  logic [7*DIGITS-1:0]   seg;
  logic                  running;
  logic                  held;
  logic                  overflow;

  modport master (output start_stop, lap, input seg, running, held, overflow);
  modport slave  (input start_stop, lap, output seg, running, held, overflow);
endinterface

// File: rtl/lap_stopwatch.sv
// Decimal run/stop stopwatch with registered active-low 7-segment outputs.
// Optional lap-hold display freeze is built when macro LAP_HOLD_EN is defined.
module lap_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 500000,
  parameter int MS_MOD   = 6
)(
  input  logic           clock,
  input  logic           reset,
  lap_stopwatch_if.slave bus
);

  localparam int              PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]      MS_MAX  = 4'(MS_MOD - 1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t                  r_state;
  logic                    r_running;
  logic [1:0]              r_ss_sync;
  logic                    r_ss_prev;
  logic [2:0]              r_fill;
  logic                    w_ss_edge;
  logic [PW-1:0]           r_presc;
  logic                    w_tick;
  logic [DIGITS-1:0][3:0]  r_digit;
  logic [DIGITS-1:0][3:0]  w_digit_nxt;
  logic [DIGITS-1:0][3:0]  w_disp;
  logic                    w_wrap;
  logic                    r_ovf;
  logic                    w_held;
  logic [7*DIGITS-1:0]     r_seg;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'b1111110;
      4'd1:    seg_pat = 7'b0110000;
      4'd2:    seg_pat = 7'b1101101;
      4'd3:    seg_pat = 7'b1111001;
      4'd4:    seg_pat = 7'b0110011;
      4'd5:    seg_pat = 7'b1011011;
      4'd6:    seg_pat = 7'b1011111;
      4'd7:    seg_pat = 7'b1110000;
      4'd8:    seg_pat = 7'b1111111;
      4'd9:    seg_pat = 7'b1111011;
      default: seg_pat = 7'b0000000;
    endcase
  endfunction

  // r_fill masks edges until the synchronizer holds only post-reset samples,
  // so a button held through reset release does not toggle anything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ss_sync <= '0;
      r_ss_prev <= 1'b0;
      r_fill    <= '0;
    end else begin
      r_ss_sync <= {r_ss_sync[0], bus.start_stop};
      r_ss_prev <= r_ss_sync[1];
      r_fill    <= {r_fill[1:0], 1'b1};
    end
  end

  assign w_ss_edge = r_fill[2] & r_ss_sync[1] & ~r_ss_prev;
  assign w_tick    = (r_state == ST_RUN) && (r_presc == PRE_MAX);

  // Ripple-carry BCD increment; carry out of the top digit means full-scale wrap.
  always_comb begin
    logic c;
    c           = w_tick;
    w_digit_nxt = r_digit;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (r_digit[k] == ((k == DIGITS - 1) ? MS_MAX : 4'd9)) begin
          w_digit_nxt[k] = 4'd0;
        end else begin
          w_digit_nxt[k] = r_digit[k] + 4'd1;
          c              = 1'b0;
        end
      end
    end
    w_wrap = c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_STOP;
      r_running <= 1'b0;
    end else if (w_ss_edge) begin
      r_state   <= (r_state == ST_RUN) ? ST_STOP : ST_RUN;
      r_running <= (r_state != ST_RUN);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
      r_digit <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == ST_RUN)
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_digit <= w_digit_nxt;
      if (w_wrap)
        r_ovf <= 1'b1;
    end
  end

`ifdef LAP_HOLD_EN
  logic [1:0]              r_lap_sync;
  logic                    r_lap_prev;
  logic                    w_lap_edge;
  logic                    r_held;
  logic [DIGITS-1:0][3:0]  r_snap;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lap_sync <= '0;
      r_lap_prev <= 1'b0;
    end else begin
      r_lap_sync <= {r_lap_sync[0], bus.lap};
      r_lap_prev <= r_lap_sync[1];
    end
  end

  assign w_lap_edge = r_fill[2] & r_lap_sync[1] & ~r_lap_prev;

  // Snapshot takes the pre-tick count when a tick lands in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_held <= 1'b0;
      r_snap <= '0;
    end else if (w_lap_edge) begin
      if (r_held) begin
        r_held <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_held <= 1'b1;
        r_snap <= r_digit;
      end
    end
  end

  assign w_held = r_held;
  assign w_disp = r_held ? r_snap : r_digit;
`else
  logic w_lap_unused;
  assign w_lap_unused = bus.lap;
  assign w_held       = 1'b0;
  assign w_disp       = r_digit;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_seg <= {DIGITS{7'b0000001}};
    end else begin
      for (int k = 0; k < DIGITS; k++)
        r_seg[7*k +: 7] <= ~seg_pat(w_disp[k]);
    end
  end

  assign bus.seg      = r_seg;
  assign bus.running  = r_running;
  assign bus.held     = w_held;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Randomized bench for lap_stopwatch against a cycle-level behavioural model
// (integer count, sample histories for the button delay).
module tb_lap_stopwatch;
  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int MS_MOD   = 6;
  localparam int FULL     = MS_MOD * 1000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  lap_stopwatch_if #(.DIGITS(DIGITS)) bus_if();

  lap_stopwatch #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .MS_MOD(MS_MOD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model state
  bit m_run, m_ovf, m_held;
  int m_presc, m_count, m_snap, m_disp;
  bit ss_s[3], ss_v[3], lp_s[3], lp_v[3];

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      default: return 7'b1111011;
    endcase
  endfunction

  function automatic logic [7*DIGITS-1:0] exp_seg(input int v);
    logic [7*DIGITS-1:0] r;
    int p;
    p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      r[7*k +: 7] = ~pat((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // One rising edge: an edge acts when the sample two edges ago was high and
  // the one three edges ago was low, both taken outside reset.
  task automatic model_step(input bit r, input bit ss, input bit lp);
    bit tick, ss_e, lp_e;
    int old_count;
    if (r) begin
      m_run = 0; m_ovf = 0; m_held = 0;
      m_presc = 0; m_count = 0; m_snap = 0; m_disp = 0;
      for (int i = 0; i < 3; i++) begin
        ss_v[i] = 0; lp_v[i] = 0; ss_s[i] = 0; lp_s[i] = 0;
      end
    end else begin
      old_count = m_count;
      m_disp = m_held ? m_snap : m_count;
      tick = m_run && (m_presc == TICK_DIV - 1);
      ss_e = ss_v[2] && ss_s[1] && !ss_s[2];
      lp_e = lp_v[2] && lp_s[1] && !lp_s[2];
      if (m_run) m_presc = tick ? 0 : m_presc + 1;
      if (tick) begin
        m_count = (m_count + 1) % FULL;
        if (m_count == 0) m_ovf = 1;
      end
`ifdef LAP_HOLD_EN
      if (lp_e) begin
        if (m_held) m_held = 0;
        else if (m_run) begin m_snap = old_count; m_held = 1; end
      end
`else
      if (lp_e) m_held = 0;
`endif
      if (ss_e) m_run = !m_run;
      ss_s[2] = ss_s[1]; ss_s[1] = ss_s[0]; ss_s[0] = ss;
      ss_v[2] = ss_v[1]; ss_v[1] = ss_v[0]; ss_v[0] = 1;
      lp_s[2] = lp_s[1]; lp_s[1] = lp_s[0]; lp_s[0] = lp;
      lp_v[2] = lp_v[1]; lp_v[1] = lp_v[0]; lp_v[0] = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit ss, input bit lp);
    reset = r;
    bus_if.start_stop = ss;
    bus_if.lap = lp;
    @(posedge clock);
    model_step(r, ss, lp);
    #1;
    chk("running",  bus_if.running,  m_run);
    chk("overflow", bus_if.overflow, m_ovf);
    chk("held",     bus_if.held,     m_held);
    chk("seg",      bus_if.seg,      exp_seg(m_disp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic press_ss(input int w);
    for (int i = 0; i < w; i++) cyc(0, 1, 0);
    idle(4);
  endtask

  task automatic press_lap(input int w);
    for (int i = 0; i < w; i++) cyc(0, 0, 1);
    idle(4);
  endtask

  task automatic run_to(input int target, input int budget);
    int g;
    g = 0;
    while (m_count != target && g < budget) begin
      cyc(0, 0, 0);
      g++;
    end
    chk("reach_count", (g < budget), 1'b1);
  endtask

  initial begin
    logic [7*DIGITS-1:0] zero_seg;
    logic [7*DIGITS-1:0] frozen;
    int g, r, w;
    zero_seg = {DIGITS{7'b0000001}};

    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    idle(100);
    chk("idle_running",  bus_if.running,  1'b0);
    chk("idle_overflow", bus_if.overflow, 1'b0);
    chk("idle_seg",      bus_if.seg,      zero_seg);

    // Start and run through full scale
    press_ss(2);
    chk("started", bus_if.running, 1'b1);
    g = 0;
    while (!m_ovf && g < 30000) begin cyc(0, 0, 0); g++; end
    chk("wrap_reached", (g < 30000), 1'b1);
    idle(20);
    chk("wrap_overflow", bus_if.overflow, 1'b1);

    // Stop at 0012, hold, resume
    run_to(12, 200);
    press_ss(1);
    chk("stopped", bus_if.running, 1'b0);
    frozen = bus_if.seg;
    idle(50);
    chk("frozen_seg", bus_if.seg, frozen);
    press_ss(2);
    chk("resumed", bus_if.running, 1'b1);

`ifdef LAP_HOLD_EN
    run_to(25, 400);
    press_lap(1);
    run_to(30, 200);
    chk("lap_hold_seg", bus_if.seg, exp_seg(25));
    press_lap(1);
    idle(2);
    chk("lap_release", bus_if.held, 1'b0);
`endif

    // Random button activity
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      w = $urandom_range(1, 4);
      if (r < 3)       press_ss(w);
      else if (r < 8)  press_lap(w);
      else if (r < 9) begin
        for (int j = 0; j < w; j++) cyc(0, 1, 1);
        idle(4);
      end else         cyc(0, 0, 0);
    end

    // Reset mid-run at 0347 with start_stop held through release
    if (!m_run) press_ss(2);
    run_to(347, 30000);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    chk("rst_held_running", bus_if.running, 1'b0);
    idle(10);
    chk("rst_running",  bus_if.running,  1'b0);
    chk("rst_overflow", bus_if.overflow, 1'b0);
    chk("rst_held",     bus_if.held,     1'b0);
    chk("rst_seg",      bus_if.seg,      zero_seg);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
